// File: rtl/ring_tdm_link_if.sv
// ring_tdm_link_if: bundles the two domain dequeue handshakes and the shared
// ring link into one port.
//   in0_*/in1_*  : domain 0/1 queue dequeue side (val/msg in, rdy out of link stage)
//   out_*        : shared link toward downstream queue (val/msg/domain out, rdy in)
// master = link stage view, slave = queue/downstream (environment) view.
interface ring_tdm_link_if #(
  parameter int p_msg_nbits = 32
);
  logic                   in0_val;
  logic                   in0_rdy;
  logic [p_msg_nbits-1:0] in0_msg;
  logic                   in1_val;
  logic                   in1_rdy;
  logic [p_msg_nbits-1:0] in1_msg;
  logic                   out_val;
  logic                   out_rdy;
  logic [p_msg_nbits-1:0] out_msg;
  logic                   out_domain;

  modport master (
    input  in0_val, in0_msg, in1_val, in1_msg, out_rdy,
    output in0_rdy, in1_rdy, out_val, out_msg, out_domain
  );

  modport slave (
    output in0_val, in0_msg, in1_val, in1_msg, out_rdy,
    input  in0_rdy, in1_rdy, out_val, out_msg, out_domain
  );
endinterface

// File: rtl/ring_tdm_link.sv
// ring_tdm_link: TDM link stage between two per-domain router output queues
// and one shared ring link. A fixed, traffic-independent schedule alternates
// SLOT (p_slot_cycles) and DRAIN (p_dead_cycles) phases per domain, so one
// domain's occupancy never perturbs the other domain's timing.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   link (master)   : in0/in1 dequeue handshakes, out link val/rdy/msg/domain
//   stat_sent0/1    : per-domain sent counters (16b, saturating) when
//                     RING_TDM_STATS_EN is defined, otherwise tied to 0
// Optional macro: RING_TDM_STATS_EN
module ring_tdm_link #(
  parameter int p_msg_nbits   = 32,
  parameter int p_slot_cycles = 4,
  parameter int p_dead_cycles = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ring_tdm_link_if.master        link,
  output logic [15:0]            stat_sent0,
  output logic [15:0]            stat_sent1
);
  localparam int c_cnt_nbits = $clog2(p_slot_cycles + p_dead_cycles) + 1;
  localparam logic [c_cnt_nbits-1:0] c_slot_last = c_cnt_nbits'(p_slot_cycles - 1);
  localparam logic [c_cnt_nbits-1:0] c_dead_last = c_cnt_nbits'(p_dead_cycles - 1);

  typedef enum logic {SLOT, DRAIN} state_t;

  state_t                 state;
  logic                   cur_dom;
  logic [c_cnt_nbits-1:0] cnt;

  logic                   buf0_full, buf1_full;
  logic [p_msg_nbits-1:0] buf0_data, buf1_data;

  logic in_slot, sel_full, deq, deq0, deq1, enq0, enq1;

  // Only the current slot's buffer is ever muxed out; the foreign buffer is
  // untouched until its own slot comes around.
  assign in_slot  = (state == SLOT);
  assign sel_full = cur_dom ? buf1_full : buf0_full;

  assign link.out_val    = in_slot & sel_full;
  assign link.out_msg    = cur_dom ? buf1_data : buf0_data;
  assign link.out_domain = cur_dom;

  assign deq  = link.out_val & link.out_rdy;
  assign deq0 = deq & ~cur_dom;
  assign deq1 = deq &  cur_dom;

  // Pipe behaviour: a full buffer can accept when it is being drained the same cycle.
  assign link.in0_rdy = in_slot & ~cur_dom & (~buf0_full | deq);
  assign link.in1_rdy = in_slot &  cur_dom & (~buf1_full | deq);

  assign enq0 = link.in0_val & link.in0_rdy;
  assign enq1 = link.in1_val & link.in1_rdy;

  // Schedule FSM: depends on nothing but time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SLOT;
      cur_dom <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        SLOT: begin
          if (cnt == c_slot_last) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == c_dead_last) begin
            state   <= SLOT;
            cnt     <= '0;
            cur_dom <= ~cur_dom;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SLOT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf0_full <= 1'b0;
      buf0_data <= '0;
      buf1_full <= 1'b0;
      buf1_data <= '0;
    end else begin
      if (enq0) begin
        buf0_full <= 1'b1;
        buf0_data <= link.in0_msg;
      end else if (deq0) begin
        buf0_full <= 1'b0;
      end
      if (enq1) begin
        buf1_full <= 1'b1;
        buf1_data <= link.in1_msg;
      end else if (deq1) begin
        buf1_full <= 1'b0;
      end
    end
  end

`ifdef RING_TDM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_sent0 <= '0;
      stat_sent1 <= '0;
    end else begin
      if (deq0 && stat_sent0 != 16'hFFFF) stat_sent0 <= stat_sent0 + 16'd1;
      if (deq1 && stat_sent1 != 16'hFFFF) stat_sent1 <= stat_sent1 + 16'd1;
    end
  end
`else
  assign stat_sent0 = 16'd0;
  assign stat_sent1 = 16'd0;
`endif
endmodule

// File: tb/tb_ring_tdm_link.sv
// Directed bench for ring_tdm_link at default parameters. Cycle 0 is the
// interval ending at the first clock edge after reset deasserts; inputs are
// driven 1ns after an edge and outputs sampled 1ns later.
module tb_ring_tdm_link;
  logic clk;
  logic reset;
  logic [15:0] stat_sent0, stat_sent1;
  int n_chk;
  int n_pass;

  ring_tdm_link_if #(.p_msg_nbits(32)) link ();

  ring_tdm_link #(
    .p_msg_nbits(32), .p_slot_cycles(4), .p_dead_cycles(1)
  ) dut (
    .clk(clk), .reset(reset), .link(link),
    .stat_sent0(stat_sent0), .stat_sent1(stat_sent1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    link.in0_val = 1'b0; link.in0_msg = '0;
    link.in1_val = 1'b0; link.in1_msg = '0;
    link.out_rdy = 1'b0;
  endtask

  // Leaves the bench 1ns into cycle 0.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [0:10] exp_dom;
    logic [0:10] exp_rdy0;
    logic [0:10] exp_rdy1;
    logic [31:0] exp_s0;
    n_chk = 0; n_pass = 0;
    reset = 1'b0;
    idle_inputs();

    // schedule with idle inputs: 0-3 dom0, 4 drain, 5-8 dom1, 9 drain, 10 dom0
    exp_dom  = 11'b00000111110;
    exp_rdy0 = 11'b11110000001;
    exp_rdy1 = 11'b00000111100;
    do_reset();
    #1;
    chk("rst_out_val", link.out_val, 0);
    chk("rst_out_msg", link.out_msg, 0);
    chk("rst_stat0", stat_sent0, 0);
    chk("rst_stat1", stat_sent1, 0);
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("sched_dom_c%0d", c), link.out_domain, exp_dom[c]);
      chk($sformatf("sched_rdy0_c%0d", c), link.in0_rdy, exp_rdy0[c]);
      chk($sformatf("sched_rdy1_c%0d", c), link.in1_rdy, exp_rdy1[c]);
      chk($sformatf("sched_val_c%0d", c), link.out_val, 0);
      nxt(); #1;
    end

    // throughput: back-to-back A5/B6/C7 with out_rdy=1
    do_reset();
    link.out_rdy = 1'b1;
    link.in0_val = 1'b1; link.in0_msg = 32'hA5; #1;
    chk("tp_c0_val", link.out_val, 0);
    chk("tp_c0_rdy0", link.in0_rdy, 1);
    nxt(); link.in0_msg = 32'hB6; #1;
    chk("tp_c1_val", link.out_val, 1);
    chk("tp_c1_msg", link.out_msg, 32'hA5);
    chk("tp_c1_rdy0", link.in0_rdy, 1);
    nxt(); link.in0_msg = 32'hC7; #1;
    chk("tp_c2_val", link.out_val, 1);
    chk("tp_c2_msg", link.out_msg, 32'hB6);
    nxt(); link.in0_val = 1'b0; #1;
    chk("tp_c3_val", link.out_val, 1);
    chk("tp_c3_msg", link.out_msg, 32'hC7);
    nxt(); #1;
    chk("tp_c4_val", link.out_val, 0);
`ifdef RING_TDM_STATS_EN
    exp_s0 = 32'd3;
`else
    exp_s0 = 32'd0;
`endif
    chk("tp_stat0", stat_sent0, exp_s0);
    chk("tp_stat1", stat_sent1, 0);

    // hold across slots with out_rdy=0
    do_reset();
    link.in0_val = 1'b1; link.in0_msg = 32'h11; #1;
    nxt(); link.in0_val = 1'b0; #1;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("hold_c%0d_val", c), link.out_val, 1);
      chk($sformatf("hold_c%0d_msg", c), link.out_msg, 32'h11);
      chk($sformatf("hold_c%0d_rdy0", c), link.in0_rdy, 0);
      nxt(); #1;
    end
    chk("hold_c4_val", link.out_val, 0);
    nxt(); link.in1_val = 1'b1; link.in1_msg = 32'h22; #1;
    chk("hold_c5_val", link.out_val, 0);
    chk("hold_c5_rdy1", link.in1_rdy, 1);
    chk("hold_c5_dom", link.out_domain, 1);
    nxt(); link.in1_val = 1'b0; #1;
    for (int c = 6; c <= 8; c++) begin
      chk($sformatf("hold_c%0d_val", c), link.out_val, 1);
      chk($sformatf("hold_c%0d_msg", c), link.out_msg, 32'h22);
      nxt(); #1;
    end
    chk("hold_c9_val", link.out_val, 0);
    nxt(); link.out_rdy = 1'b1; #1;
    chk("hold_c10_val", link.out_val, 1);
    chk("hold_c10_msg", link.out_msg, 32'h11);
    chk("hold_c10_dom", link.out_domain, 0);
    chk("hold_c10_rdy0", link.in0_rdy, 1);
    nxt(); #1;
    chk("hold_c11_val", link.out_val, 0);
`ifdef RING_TDM_STATS_EN
    exp_s0 = 32'd1;
`else
    exp_s0 = 32'd0;
`endif
    chk("hold_stat0", stat_sent0, exp_s0);
    chk("hold_stat1", stat_sent1, 0);

    // isolation: domain-1 traffic waits for its own slot
    do_reset();
    link.out_rdy = 1'b1;
    link.in1_val = 1'b1; link.in1_msg = 32'h33; #1;
    for (int c = 0; c <= 4; c++) begin
      chk($sformatf("iso_c%0d_rdy1", c), link.in1_rdy, 0);
      chk($sformatf("iso_c%0d_val", c), link.out_val, 0);
      nxt(); #1;
    end
    chk("iso_c5_rdy1", link.in1_rdy, 1);
    nxt(); link.in1_val = 1'b0; #1;
    chk("iso_c6_val", link.out_val, 1);
    chk("iso_c6_msg", link.out_msg, 32'h33);
    chk("iso_c6_dom", link.out_domain, 1);

    // last-cycle enqueue
    do_reset();
    link.out_rdy = 1'b1;
    nxt(); nxt(); nxt();
    link.in0_val = 1'b1; link.in0_msg = 32'h44; #1;
    chk("last_c3_rdy0", link.in0_rdy, 1);
    nxt(); link.in0_val = 1'b0; #1;
    for (int c = 4; c <= 9; c++) begin
      chk($sformatf("last_c%0d_val", c), link.out_val, 0);
      nxt(); #1;
    end
    chk("last_c10_val", link.out_val, 1);
    chk("last_c10_msg", link.out_msg, 32'h44);

    // async reset at cycle 2 with buf0 full, between edges
    do_reset();
    link.in0_val = 1'b1; link.in0_msg = 32'h55; #1;
    nxt(); link.in0_val = 1'b0; #1;
    nxt(); #1;
    chk("arst_pre_val", link.out_val, 1);
    #2 reset = 1'b1; #1;
    chk("arst_val", link.out_val, 0);
    chk("arst_dom", link.out_domain, 0);
    chk("arst_msg", link.out_msg, 0);
    chk("arst_rdy0", link.in0_rdy, 1);
    chk("arst_rdy1", link.in1_rdy, 0);
    chk("arst_stat0", stat_sent0, 0);
    // after release the schedule restarts at cnt=0: 4 slot cycles, then drain
    @(posedge clk); #1;
    reset = 1'b0; #1;
    for (int c = 0; c <= 3; c++) begin
      chk($sformatf("arst_sched_c%0d", c), link.in0_rdy, 1);
      nxt(); #1;
    end
    chk("arst_sched_c4", link.in0_rdy, 0);

    // async reset during domain-1 slot forces domain back to 0
    do_reset();
    for (int c = 0; c < 7; c++) nxt();
    #1;
    chk("arst2_pre_dom", link.out_domain, 1);
    #2 reset = 1'b1; #1;
    chk("arst2_dom", link.out_domain, 0);
    chk("arst2_rdy0", link.in0_rdy, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
